fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
Control sequencer for a time-multiplexed FIR datapath: one shared multiply-accumulate unit, a circular sample delay-line RAM and a coefficient ROM.
- Accepts one input sample per valid/ready handshake and writes it into the delay line.
- Steps the MAC through all TAPS products, then pulses the load enable of the output register.
- Holds out_valid until downstream accepts.
- Replaces free-running cycle counting as the source of the output-register enable.

Parameters:
TAPS, 16, number of filter taps; legal range 2..2**ADDR_W
ADDR_W, 4, width of delay-line and coefficient addresses

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state
in_valid  in  1  upstream sample available
in_ready  out  1  sequencer can accept a sample
smp_we  out  1  delay-line write enable
smp_wr_addr  out  ADDR_W  delay-line write address
smp_rd_addr  out  ADDR_W  delay-line read address
coef_addr  out  ADDR_W  coefficient ROM address
mac_clr  out  1  MAC loads product instead of accumulating
mac_en  out  1  MAC update enable
out_load  out  1  one-cycle enable for output register
out_valid  out  1  filtered result held in output register
out_ready  in  1  downstream accepts result
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - State goes to IDLE; wr_ptr, base and k all become 0.
  - Every output is 0 during and after reset, except in_ready=1 once in IDLE.
  - Delay-line contents are not cleared; that is out of scope.
- States: IDLE, MAC, DRAIN, HOLD. All outputs decode from registered state and counters; the only exception is smp_we.
- IDLE:
  - in_ready=1 and smp_wr_addr=wr_ptr.
  - smp_we=in_valid&in_ready, combinational, within the handshake cycle.
  - On handshake:
    - base<=wr_ptr.
    - wr_ptr<=(wr_ptr==TAPS-1)?0:wr_ptr+1.
    - k<=0.
    - Next state is MAC.
- MAC: lasts exactly TAPS cycles, k=0..TAPS-1.
  - coef_addr=k.
  - smp_rd_addr=(base-k) mod TAPS, computed with an explicit +TAPS correction when base<k. This must be correct for non-power-of-two TAPS.
  - mac_en=1.
  - mac_clr=1 only when k==0.
  - k increments each cycle. When k==TAPS-1, next state is DRAIN.
- DRAIN: one cycle, covering the MAC output register latency.
  - out_load=1, mac_en=0.
  - Next state is HOLD.
- HOLD:
  - out_valid=1.
  - If out_ready, next state is IDLE.
  - out_ready sampled in the same cycle out_valid first rises completes the transfer.
- Latency: handshake at cycle 0 gives MAC in cycles 1..TAPS, out_load at TAPS+1, and out_valid first high at TAPS+2. Minimum sample period is TAPS+3 cycles.
- in_ready=0 in MAC, DRAIN and HOLD. in_valid in those states is ignored: no write and no pointer change.
- out_ready outside HOLD has no effect.
- Wrap-around: wr_ptr goes TAPS-1 -> 0. The read sequence from base=0 is 0, TAPS-1, TAPS-2, ..., 1.
- Reset mid-operation (any state): abort immediately.
  - No out_load, no out_valid.
  - wr_ptr returns to 0; the partial accumulation is discarded.
- mac_clr and mac_en are never asserted outside MAC.
- out_load is never asserted outside DRAIN.

Test Plan:
- Reset, then idle 5 cycles -> in_ready=1, busy=0, all other outputs 0, wr_ptr=0.
- TAPS=16: single sample, in_valid for 1 cycle at cycle 0 -> smp_we=1 with wr_addr=0 at cycle 0.
  - Cycles 1-16: rd_addr 0,15,14,...,1; coef_addr 0..15; mac_clr only at cycle 1.
  - out_load at cycle 17; out_valid from cycle 18.
- out_ready low for 10 cycles after out_valid rises -> out_valid held; in_valid pulses ignored (no smp_we); out_ready=1 -> IDLE next cycle.
- 17 back-to-back samples with out_ready=1 -> wr_addr 0..15 then 0; sample 17 has base=0 again; each transfer spaced 19 cycles.
- TAPS=5, ADDR_W=3, third sample (base=2) -> rd_addr 2,1,0,4,3; wr_ptr wraps 4->0.
- reset asserted at k=7 of MAC -> all outputs 0 asynchronously; no out_load; the next sample is written at wr_addr=0.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// Control sequencer for a time-multiplexed FIR: accepts a sample, walks the
// shared MAC over all taps, then loads and holds the output register.
`timescale 1ns/1ps
module fir_mac_sequencer #(
    parameter int TAPS   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              smp_we,
    output logic [ADDR_W-1:0] smp_wr_addr,
    output logic [ADDR_W-1:0] smp_rd_addr,
    output logic [ADDR_W-1:0] coef_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              out_load,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(TAPS - 1);
    localparam logic [ADDR_W:0]   TAPS_X = (ADDR_W + 1)'(TAPS);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [ADDR_W-1:0] k_q, k_d;
    logic              handshake;
    logic              in_mac;
    logic [ADDR_W:0]   rd_wide;

    assign handshake = in_valid && (state_q == S_IDLE);
    assign in_mac    = (state_q == S_MAC);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        base_d   = base_q;
        k_d      = k_q;
        case (state_q)
            S_IDLE: begin
                if (handshake) begin
                    base_d   = wr_ptr_q;
                    wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                    k_d      = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                if (k_q == LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_DRAIN: state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            base_q   <= '0;
            k_q      <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            base_q   <= base_d;
            k_q      <= k_d;
        end
    end

    // Newest sample first: (base - k) mod TAPS, with an explicit wrap so
    // non-power-of-two tap counts stay inside the delay line.
    always_comb begin
        if (base_q >= k_q) begin
            rd_wide = {1'b0, base_q} - {1'b0, k_q};
        end else begin
            rd_wide = {1'b0, base_q} + TAPS_X - {1'b0, k_q};
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign smp_we      = handshake;
    assign smp_wr_addr = (state_q == S_IDLE) ? wr_ptr_q : '0;
    assign smp_rd_addr = in_mac ? rd_wide[ADDR_W-1:0] : '0;
    assign coef_addr   = in_mac ? k_q : '0;
    assign mac_en      = in_mac;
    assign mac_clr     = in_mac && (k_q == '0);
    assign out_load    = (state_q == S_DRAIN);
    assign out_valid   = (state_q == S_HOLD);
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: a 16-tap and a 5-tap instance checked against
// a cycle-phase reference model, a vector table and directed corner sequences.
`timescale 1ns/1ps
module tb_fir_mac_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       iv16, or16, ir16, we16, clr16, en16, ld16, ov16, busy16;
    logic [3:0] wa16, ra16, ca16;
    logic       iv5, or5, ir5, we5, clr5, en5, ld5, ov5, busy5;
    logic [2:0] wa5, ra5, ca5;

    fir_mac_sequencer #(.TAPS(16), .ADDR_W(4)) dut16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16),
        .smp_we(we16), .smp_wr_addr(wa16), .smp_rd_addr(ra16), .coef_addr(ca16),
        .mac_clr(clr16), .mac_en(en16), .out_load(ld16), .out_valid(ov16),
        .out_ready(or16), .busy(busy16)
    );

    fir_mac_sequencer #(.TAPS(5), .ADDR_W(3)) dut5 (
        .clk(clk), .reset(reset), .in_valid(iv5), .in_ready(ir5),
        .smp_we(we5), .smp_wr_addr(wa5), .smp_rd_addr(ra5), .coef_addr(ca5),
        .mac_clr(clr5), .mac_en(en5), .out_load(ld5), .out_valid(ov5),
        .out_ready(or5), .busy(busy5)
    );

    typedef struct packed {
        logic       in_ready;
        logic       smp_we;
        logic [4:0] wr;
        logic [4:0] rd;
        logic [4:0] coef;
        logic       clr;
        logic       en;
        logic       load;
        logic       ov;
        logic       busy;
    } obs_t;

    typedef struct packed {
        logic iv;
        logic orr;
        obs_t exp;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Reference model: ph = 0 idle, else cycles elapsed since the handshake.
    int ph16 = 0, wr16 = 0, base16 = 0;
    int ph5 = 0, wr5 = 0, base5 = 0;
    int cyc = 0;
    int hs16_cyc[$], hs16_addr[$], hs5_addr[$], rd5_q[$];

    function automatic string fmt(obs_t o);
        return $sformatf("rdy=%0d we=%0d wr=%0d rd=%0d coef=%0d clr=%0d en=%0d load=%0d ov=%0d busy=%0d",
                         o.in_ready, o.smp_we, o.wr, o.rd, o.coef, o.clr, o.en, o.load, o.ov, o.busy);
    endfunction

    function automatic obs_t obs16();
        obs_t o;
        o.in_ready = ir16; o.smp_we = we16; o.wr = 5'(wa16); o.rd = 5'(ra16);
        o.coef = 5'(ca16); o.clr = clr16; o.en = en16; o.load = ld16;
        o.ov = ov16; o.busy = busy16;
        return o;
    endfunction

    function automatic obs_t obs5();
        obs_t o;
        o.in_ready = ir5; o.smp_we = we5; o.wr = 5'(wa5); o.rd = 5'(ra5);
        o.coef = 5'(ca5); o.clr = clr5; o.en = en5; o.load = ld5;
        o.ov = ov5; o.busy = busy5;
        return o;
    endfunction

    function automatic obs_t model(int taps, int ph, int wr, int base, logic iv);
        obs_t o;
        o = '0;
        if (ph == 0) begin
            o.in_ready = 1'b1;
            o.smp_we   = iv;
            o.wr       = 5'(wr);
        end else if (ph <= taps) begin
            int k;
            k      = ph - 1;
            o.rd   = 5'((base - k + taps) % taps);
            o.coef = 5'(k);
            o.en   = 1'b1;
            o.clr  = (k == 0);
            o.busy = 1'b1;
        end else if (ph == taps + 1) begin
            o.load = 1'b1;
            o.busy = 1'b1;
        end else begin
            o.ov   = 1'b1;
            o.busy = 1'b1;
        end
        return o;
    endfunction

    task automatic adv(input int taps, input logic iv, input logic orr,
                       inout int ph, inout int wr, inout int base);
        if (ph == 0) begin
            if (iv) begin
                base = wr;
                wr   = (wr + 1) % taps;
                ph   = 1;
            end
        end else if (ph <= taps + 1) begin
            ph = ph + 1;
        end else if (orr) begin
            ph = 0;
        end
    endtask

    task automatic check(input string nm, input obs_t a, input obs_t e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @cyc %0d: got {%s} expected {%s}", nm, cyc, fmt(a), fmt(e));
        end
    endtask

    task automatic check_int(input string nm, input int a, input int e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, a, e);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic a_iv, input logic a_or, input logic b_iv, input logic b_or,
                        input string nm);
        iv16 = a_iv; or16 = a_or; iv5 = b_iv; or5 = b_or;
        #1;
        check({nm, "/t16"}, obs16(), model(16, ph16, wr16, base16, a_iv));
        check({nm, "/t5"},  obs5(),  model(5, ph5, wr5, base5, b_iv));
        if (we16) begin hs16_cyc.push_back(cyc); hs16_addr.push_back(int'(wa16)); end
        if (we5)  hs5_addr.push_back(int'(wa5));
        if (en5)  rd5_q.push_back(int'(ra5));
        @(posedge clk);
        adv(16, a_iv, a_or, ph16, wr16, base16);
        adv(5, b_iv, b_or, ph5, wr5, base5);
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset(input string nm);
        obs_t e;
        e = '0;
        e.in_ready = 1'b1;
        iv16 = 1'b0; iv5 = 1'b0; or16 = 1'b0; or5 = 1'b0;
        reset = 1'b1;
        #1;
        check({nm, "/rst16"}, obs16(), e);
        check({nm, "/rst5"},  obs5(),  e);
        ph16 = 0; wr16 = 0; base16 = 0;
        ph5 = 0; wr5 = 0; base5 = 0;
        @(negedge clk);
        check({nm, "/rsthold16"}, obs16(), e);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[30];
        obs_t e;

        for (int c = 0; c < 30; c++) begin
            vec_t v;
            v = '0;
            if (c == 0) begin
                v.iv = 1'b1; v.exp.in_ready = 1'b1; v.exp.smp_we = 1'b1; v.exp.wr = 5'd0;
            end else if (c <= 16) begin
                v.iv = (c % 3 == 0);
                v.exp.rd = (c == 1) ? 5'd0 : 5'(17 - c);
                v.exp.coef = 5'(c - 1);
                v.exp.en = 1'b1; v.exp.clr = (c == 1); v.exp.busy = 1'b1;
            end else if (c == 17) begin
                v.iv = 1'b1; v.exp.load = 1'b1; v.exp.busy = 1'b1;
            end else if (c <= 27) begin
                v.iv = (c % 2 == 1); v.exp.ov = 1'b1; v.exp.busy = 1'b1;
            end else if (c == 28) begin
                v.orr = 1'b1; v.exp.ov = 1'b1; v.exp.busy = 1'b1;
            end else begin
                v.exp.in_ready = 1'b1; v.exp.wr = 5'd1;
            end
            tbl[c] = v;
        end

        reset = 1'b1;
        iv16 = 1'b0; iv5 = 1'b0; or16 = 1'b0; or5 = 1'b0;
        @(negedge clk);
        do_reset("init");

        for (int i = 0; i < 5; i++) tick(1'b0, 1'b0, 1'b0, 1'b0, "idle");
        check_int("idle busy16", int'(busy16), 0);
        check_int("idle wr_ptr16", int'(wa16), 0);

        // Single sample, stalled output, ignored in_valid pulses.
        for (int c = 0; c < 30; c++) begin
            iv16 = tbl[c].iv; or16 = tbl[c].orr; iv5 = 1'b0; or5 = 1'b0;
            #1;
            check($sformatf("table[%0d]", c), obs16(), tbl[c].exp);
            @(posedge clk);
            adv(16, tbl[c].iv, tbl[c].orr, ph16, wr16, base16);
            adv(5, 1'b0, 1'b0, ph5, wr5, base5);
            cyc++;
            @(negedge clk);
        end

        // 17 back-to-back samples with downstream always ready.
        do_reset("b2b");
        hs16_cyc.delete(); hs16_addr.delete();
        for (int i = 0; i < 17 * 19; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, "b2b");
        check_int("b2b count", hs16_addr.size(), 17);
        for (int i = 0; i < hs16_addr.size() && i < 17; i++) begin
            check_int($sformatf("b2b wr_addr[%0d]", i), hs16_addr[i], i % 16);
            if (i > 0) check_int($sformatf("b2b spacing[%0d]", i), hs16_cyc[i] - hs16_cyc[i-1], 19);
        end

        // Five-tap instance: wrap of wr_ptr and non-power-of-two read order.
        do_reset("t5");
        hs5_addr.delete(); rd5_q.delete();
        for (int i = 0; i < 6 * 8; i++) tick(1'b0, 1'b0, 1'b1, 1'b1, "t5");
        begin
            int exp_wr[6];
            int exp_rd[5];
            exp_wr = '{0, 1, 2, 3, 4, 0};
            exp_rd = '{2, 1, 0, 4, 3};
            check_int("t5 count", hs5_addr.size(), 6);
            for (int i = 0; i < 6 && i < hs5_addr.size(); i++)
                check_int($sformatf("t5 wr_addr[%0d]", i), hs5_addr[i], exp_wr[i]);
            check_int("t5 rd count", rd5_q.size(), 30);
            for (int i = 0; i < 5 && 10 + i < rd5_q.size(); i++)
                check_int($sformatf("t5 base2 rd[%0d]", i), rd5_q[10 + i], exp_rd[i]);
        end

        // Abort in the middle of accumulation.
        do_reset("abort");
        tick(1'b1, 1'b1, 1'b0, 1'b0, "abort");
        for (int i = 0; i < 7; i++) tick(1'b0, 1'b1, 1'b0, 1'b0, "abort");
        #1;
        check_int("abort coef before reset", int'(ca16), 7);
        check_int("abort wr_ptr before reset", ph16 > 0 ? wr16 : -1, 1);
        reset = 1'b1;
        #1;
        e = '0;
        e.in_ready = 1'b1;
        check("abort async", obs16(), e);
        ph16 = 0; wr16 = 0; base16 = 0;
        ph5 = 0; wr5 = 0; base5 = 0;
        @(negedge clk);
        check("abort held", obs16(), e);
        reset = 1'b0;
        hs16_addr.delete(); hs16_cyc.delete();
        for (int i = 0; i < 22; i++) tick(1'b1, 1'b1, 1'b0, 1'b0, "post-abort");
        check_int("post-abort count", hs16_addr.size(), 2);
        if (hs16_addr.size() > 0) check_int("post-abort wr_addr", hs16_addr[0], 0);

        // Random traffic on both instances.
        do_reset("rand");
        for (int i = 0; i < 800; i++) begin
            logic a, b, c2, d;
            a  = ($urandom_range(0, 1) == 1);
            b  = ($urandom_range(0, 3) != 0);
            c2 = ($urandom_range(0, 1) == 1);
            d  = ($urandom_range(0, 2) != 0);
            tick(a, b, c2, d, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
